// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// mem_initiator : sequences byte / 16-bit LE requests into single-byte memory
// cycles. Optional MEM_INITIATOR_PAGE_WRAP_EN adds the req_page_wrap input.
// Revision : 1.0
// ============================================================================
module mem_initiator #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic                req_word,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
`ifdef MEM_INITIATOR_PAGE_WRAP_EN
   input  logic                req_page_wrap,
`endif
   output logic                rsp_valid,
   output logic [2*DATA_W-1:0] rsp_data,
   output logic                busy,
   output logic                mem_enable,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_wr_enable,
   output logic [DATA_W-1:0]   mem_wr_data,
   input  logic [DATA_W-1:0]   mem_rd_data
);

   localparam int               CNT_W       = 4;
   localparam logic [CNT_W-1:0] c_wait_init = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE_LO = 3'd1,
      S_WAIT_LO  = 3'd2,
      S_ISSUE_HI = 3'd3,
      S_WAIT_HI  = 3'd4,
      S_RESP     = 3'd5
   } state_t;

   state_t                r_state;
   logic                  r_write;
   logic                  r_word;
   logic [ADDR_W-1:0]     r_addr_hi;
   logic [DATA_W-1:0]     r_wdata_hi;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_rd_lo;
   logic                  r_req_ready;
   logic                  r_busy;
   logic                  r_rsp_valid;
   logic [2*DATA_W-1:0]   r_rsp_data;
   logic                  r_mem_enable;
   logic [ADDR_W-1:0]     r_mem_address;
   logic                  r_mem_wr_enable;
   logic [DATA_W-1:0]     r_mem_wr_data;

   state_t                w_state_nxt;
   logic                  w_write_nxt;
   logic                  w_word_nxt;
   logic [ADDR_W-1:0]     w_addr_hi_nxt;
   logic [DATA_W-1:0]     w_wdata_hi_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [DATA_W-1:0]     w_rd_lo_nxt;
   logic                  w_rsp_valid_nxt;
   logic [2*DATA_W-1:0]   w_rsp_data_nxt;
   logic                  w_mem_enable_nxt;
   logic [ADDR_W-1:0]     w_mem_address_nxt;
   logic                  w_mem_wr_enable_nxt;
   logic [DATA_W-1:0]     w_mem_wr_data_nxt;
   logic [ADDR_W-1:0]     w_addr_inc;

   // Address of the second byte; page wrap keeps the carry out of addr[ADDR_W-1:8].
   always_comb begin
      w_addr_inc = req_addr + ADDR_W'(1);
`ifdef MEM_INITIATOR_PAGE_WRAP_EN
      if (req_page_wrap) begin
         w_addr_inc = {req_addr[ADDR_W-1:8], req_addr[7:0] + 8'd1};
      end
`endif
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_write_nxt         = r_write;
      w_word_nxt          = r_word;
      w_addr_hi_nxt       = r_addr_hi;
      w_wdata_hi_nxt      = r_wdata_hi;
      w_cnt_nxt           = r_cnt;
      w_rd_lo_nxt         = r_rd_lo;
      w_rsp_valid_nxt     = 1'b0;
      w_rsp_data_nxt      = r_rsp_data;
      w_mem_enable_nxt    = 1'b0;
      w_mem_address_nxt   = r_mem_address;
      w_mem_wr_enable_nxt = 1'b0;
      w_mem_wr_data_nxt   = r_mem_wr_data;

      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_nxt         = S_ISSUE_LO;
               w_write_nxt         = req_write;
               w_word_nxt          = req_word;
               w_addr_hi_nxt       = w_addr_inc;
               w_wdata_hi_nxt      = req_wdata[2*DATA_W-1:DATA_W];
               w_mem_enable_nxt    = 1'b1;
               w_mem_address_nxt   = req_addr;
               w_mem_wr_enable_nxt = req_write;
               if (req_write) begin
                  w_mem_wr_data_nxt = req_wdata[DATA_W-1:0];
               end
            end
         end

         S_ISSUE_LO: begin
            if (r_write) begin
               if (r_word) begin
                  w_state_nxt         = S_ISSUE_HI;
                  w_mem_enable_nxt    = 1'b1;
                  w_mem_address_nxt   = r_addr_hi;
                  w_mem_wr_enable_nxt = 1'b1;
                  w_mem_wr_data_nxt   = r_wdata_hi;
               end else begin
                  w_state_nxt     = S_RESP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_data_nxt  = '0;
               end
            end else begin
               w_state_nxt = S_WAIT_LO;
               w_cnt_nxt   = c_wait_init;
            end
         end

         S_WAIT_LO: begin
            if (r_cnt == '0) begin
               if (r_word) begin
                  w_state_nxt       = S_ISSUE_HI;
                  w_rd_lo_nxt       = mem_rd_data;
                  w_mem_enable_nxt  = 1'b1;
                  w_mem_address_nxt = r_addr_hi;
               end else begin
                  w_state_nxt     = S_RESP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_data_nxt  = {{DATA_W{1'b0}}, mem_rd_data};
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         S_ISSUE_HI: begin
            if (r_write) begin
               w_state_nxt     = S_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = '0;
            end else begin
               w_state_nxt = S_WAIT_HI;
               w_cnt_nxt   = c_wait_init;
            end
         end

         S_WAIT_HI: begin
            if (r_cnt == '0) begin
               w_state_nxt     = S_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = {mem_rd_data, r_rd_lo};
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         S_RESP: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // rsp_data only changes when a response is issued, so it holds between responses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state         <= S_IDLE;
         r_write         <= 1'b0;
         r_word          <= 1'b0;
         r_addr_hi       <= '0;
         r_wdata_hi      <= '0;
         r_cnt           <= '0;
         r_rd_lo         <= '0;
         r_req_ready     <= 1'b1;
         r_busy          <= 1'b0;
         r_rsp_valid     <= 1'b0;
         r_rsp_data      <= '0;
         r_mem_enable    <= 1'b0;
         r_mem_address   <= '0;
         r_mem_wr_enable <= 1'b0;
         r_mem_wr_data   <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_write         <= w_write_nxt;
         r_word          <= w_word_nxt;
         r_addr_hi       <= w_addr_hi_nxt;
         r_wdata_hi      <= w_wdata_hi_nxt;
         r_cnt           <= w_cnt_nxt;
         r_rd_lo         <= w_rd_lo_nxt;
         r_req_ready     <= (w_state_nxt == S_IDLE);
         r_busy          <= (w_state_nxt != S_IDLE);
         r_rsp_valid     <= w_rsp_valid_nxt;
         r_rsp_data      <= w_rsp_data_nxt;
         r_mem_enable    <= w_mem_enable_nxt;
         r_mem_address   <= w_mem_address_nxt;
         r_mem_wr_enable <= w_mem_wr_enable_nxt;
         r_mem_wr_data   <= w_mem_wr_data_nxt;
      end
   end

   assign req_ready     = r_req_ready;
   assign busy          = r_busy;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign mem_enable    = r_mem_enable;
   assign mem_address   = r_mem_address;
   assign mem_wr_enable = r_mem_wr_enable;
   assign mem_wr_data   = r_mem_wr_data;

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-side initiator that drives the 64 kB behavioural memory port (enable, address, wr_enable, wr_data, rd_data) on behalf of the CPU core.
- Accepts byte or 16-bit little-endian word requests over a valid/ready handshake.
- Sequences them as single-byte memory cycles, waits a fixed read latency and returns the result as a one-cycle response pulse.
- Sits between the 6502 core's address/data logic and the memory model; used for vector fetches, indirect pointers and stack pushes.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- RD_LATENCY, 1, clock edges from the edge that samples mem_enable to the edge where mem_rd_data is captured; legal range 1..15.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_word  in  1  1 = two-byte access (addr, addr+1), 0 = single byte.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  2*DATA_W  write data; low byte goes to addr, high byte to addr+1.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  2*DATA_W  read result, {hi,lo}; hi = 0 for byte reads; 0 for writes.
- busy  out  1  request in flight (not IDLE).
- mem_enable  out  1  memory enable.
- mem_address  out  ADDR_W  memory address.
- mem_wr_enable  out  1  memory write strobe.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data.

Behaviour:
- Reset: clk and resetn as decided; resetn sampled low at a rising edge forces the following.
  - State goes to IDLE.
  - req_ready=1 and busy=0.
  - rsp_valid=0 and rsp_data=0.
  - mem_enable=0, mem_wr_enable=0, mem_address=0, mem_wr_data=0.
  - Wait counter and latched request are cleared.
  - Reset mid-operation abandons the request with no response. A low byte already written stays written.
- All outputs are registered.
- States and transitions:
  - IDLE -> ISSUE_LO on accept (req_valid & req_ready at an edge). req_ready=1 only in IDLE.
  - ISSUE_LO: exactly one cycle with mem_enable=1 and mem_address=addr.
    - Write: mem_wr_enable=1 and mem_wr_data=wdata[DATA_W-1:0].
    - Next state is WAIT_LO for a read, ISSUE_HI for a word write, RESP for a byte write.
  - WAIT_LO: mem_enable=0; lasts RD_LATENCY cycles. On its final edge mem_rd_data is captured into rsp_data low byte. Next state is ISSUE_HI for a word, RESP otherwise.
  - ISSUE_HI: as ISSUE_LO, using addr_hi and the high write byte. Next state is WAIT_HI for a read, RESP for a write.
  - WAIT_HI: as WAIT_LO; captures the high byte, then goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Response: rsp_data holds its value until the next response. There is no response backpressure; the consumer must take the data in the rsp_valid cycle.
- Request latch: the whole request is latched at accept. Request inputs are ignored while busy.
- Latency from accept edge to rsp_valid cycle:
  - byte write: 2 cycles.
  - byte read: 2+RD_LATENCY cycles.
  - word write: 3 cycles.
  - word read: 3+2*RD_LATENCY cycles.
- Back-to-back requests are separated by at least one IDLE cycle.
- addr_hi = addr+1 modulo 2**ADDR_W, so 0xFFFF wraps to 0x0000 (subject to the optional feature).
- Between accesses mem_address and mem_wr_data hold their last values; mem_enable=0 and mem_wr_enable=0.

Optional Feature:
- Macro: MEM_INITIATOR_PAGE_WRAP_EN.
- Defined: adds input req_page_wrap (1 bit), latched at accept. When it is set on a word access, addr_hi = {addr[ADDR_W-1:8], addr[7:0]+1}, so the carry does not propagate into the page. This reproduces the 6502 JMP-indirect and zero-page pointer wrap.
- Undefined: the port is absent and addr_hi is always a full ADDR_W-bit increment.

Test Plan:
- Memory preloaded 0x1234=0xAB; byte read of 0x1234 with RD_LATENCY=1 -> mem_enable high for exactly one cycle with address 0x1234; rsp_valid 3 cycles after accept; rsp_data=0x00AB.
- Word write 0x0200 with wdata 0xBEEF, then word read 0x0200 -> memory holds [0x0200]=0xEF and [0x0201]=0xBE; read returns rsp_data=0xBEEF 5 cycles after accept.
- Word read 0xFFFC with [FFFC]=0x00 and [FFFD]=0x80 (reset vector) -> rsp_data=0x8000. Word read at 0xFFFF -> high byte fetched from 0x0000.
- With the macro defined, word read 0x02FF with req_page_wrap=1 -> second access at 0x0200. With req_page_wrap=0 -> second access at 0x0300.
- req_valid held high continuously with changing addresses -> only one accept per transaction; req_ready=0 while busy; no request is lost or duplicated; a scoreboard matches the response order.
- resetn low during WAIT_HI of a word read -> the next edge gives IDLE, req_ready=1, mem_enable=0 and no rsp_valid. A new byte read after reset completes normally.
